// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer_pkg
// Desc   : Shared sizing constants and entry record for the reorder buffer.
// Rev    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

  localparam int ROB_SIZE = 16;
  localparam int ROB_AW   = 4;

  // Tag with the MSB set never names a real entry.
  localparam logic [ROB_AW:0] ENTRY_NULL = {1'b1, {ROB_AW{1'b0}}};
  localparam logic [ROB_AW:0] COUNT_FULL = ENTRY_NULL;
  localparam logic [5:0]      REG_NULL   = 6'd32;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        is_br;
    logic        is_st;
    logic        pred;
    logic        taken;
    logic [5:0]  rd;
    logic [31:0] pc;
    logic [31:0] value;
    logic [31:0] target;
  } rob_ent_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_bypass_mux.sv
`default_nettype none
// ============================================================================
// Module : rob_bypass_mux
// Desc   : Operand-tag lookup into the ROB with same-cycle CDB forwarding.
//          Only compiled when ROB_BYPASS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`ifdef ROB_BYPASS_EN
module rob_bypass_mux
  import reorder_buffer_pkg::*;
(
  input  logic [ROB_AW:0]              i_tag,
  input  logic [ROB_SIZE-1:0]          i_busy,
  input  logic [ROB_SIZE-1:0]          i_ready,
  input  logic [ROB_SIZE-1:0][31:0]    i_value,
  input  logic                         i_alu_valid,
  input  logic [ROB_AW:0]              i_alu_entry,
  input  logic [31:0]                  i_alu_value,
  input  logic                         i_lsb_valid,
  input  logic [ROB_AW:0]              i_lsb_entry,
  input  logic [31:0]                  i_lsb_value,
  output logic                         o_rdy,
  output logic [31:0]                  o_val
);

  logic [ROB_AW-1:0] w_idx;
  logic              w_live;

  assign w_idx  = i_tag[ROB_AW-1:0];
  assign w_live = !i_tag[ROB_AW] && i_busy[w_idx];

  // Stored result wins; otherwise catch the broadcast that is on the bus now.
  always_comb begin
    o_rdy = 1'b0;
    o_val = '0;
    if (w_live) begin
      if (i_ready[w_idx]) begin
        o_rdy = 1'b1;
        o_val = i_value[w_idx];
      end else if (i_alu_valid && (i_alu_entry == i_tag)) begin
        o_rdy = 1'b1;
        o_val = i_alu_value;
      end else if (i_lsb_valid && (i_lsb_entry == i_tag)) begin
        o_rdy = 1'b1;
        o_val = i_lsb_value;
      end
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module : reorder_buffer
// Desc   : 16-entry circular in-order ROB: allocate, CDB capture, in-order
//          retire, mispredict rollback. Optional operand bypass: ROB_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              issue_sgn,
  input  logic [5:0]        issue_rd,
  input  logic              issue_is_br,
  input  logic              issue_is_st,
  input  logic              issue_pred,
  input  logic [31:0]       issue_pc,
  output logic [ROB_AW:0]   rob_new_entry,
  output logic              rob_full,
  input  logic              alu_valid,
  input  logic [ROB_AW:0]   alu_entry,
  input  logic [31:0]       alu_value,
  input  logic              alu_taken,
  input  logic [31:0]       alu_target,
  input  logic              lsb_valid,
  input  logic [ROB_AW:0]   lsb_entry,
  input  logic [31:0]       lsb_value,
  input  logic [ROB_AW:0]   qry_j,
  input  logic [ROB_AW:0]   qry_k,
  output logic              qry_j_rdy,
  output logic [31:0]       qry_j_val,
  output logic              qry_k_rdy,
  output logic [31:0]       qry_k_val,
  output logic              commit_sgn,
  output logic [ROB_AW:0]   rob_entry,
  output logic [5:0]        rob_des,
  output logic [31:0]       rob_result,
  output logic              st_commit,
  output logic              rollback,
  output logic [31:0]       rollback_pc
);

  rob_ent_t          r_rob [ROB_SIZE];
  logic [ROB_AW-1:0] r_head;
  logic [ROB_AW-1:0] r_tail;
  logic [ROB_AW:0]   r_count;
  logic              r_commit_sgn;
  logic              r_st_commit;
  logic              r_rollback;
  logic [ROB_AW:0]   r_rob_entry;
  logic [5:0]        r_rob_des;
  logic [31:0]       r_rob_result;
  logic [31:0]       r_rollback_pc;

  rob_ent_t          w_head;
  logic              w_full;
  logic              w_issue;
  logic              w_commit;
  logic              w_mispred;
  logic              w_alu_hit;
  logic              w_lsb_hit;
  logic [ROB_AW-1:0] w_alu_idx;
  logic [ROB_AW-1:0] w_lsb_idx;

  assign w_head    = r_rob[r_head];
  assign w_full    = (r_count == COUNT_FULL);
  assign w_alu_idx = alu_entry[ROB_AW-1:0];
  assign w_lsb_idx = lsb_entry[ROB_AW-1:0];

  // While the rollback pulse is out, everything waits for the flush edge.
  assign w_issue   = issue_sgn && !w_full && !r_rollback;
  assign w_commit  = w_head.busy && w_head.ready && !r_rollback;
  assign w_alu_hit = alu_valid && !alu_entry[ROB_AW] && r_rob[w_alu_idx].busy && !r_rollback;
  assign w_lsb_hit = lsb_valid && !lsb_entry[ROB_AW] && r_rob[w_lsb_idx].busy && !r_rollback;
  assign w_mispred = w_head.is_br && (w_head.taken != w_head.pred);

  always_ff @(posedge clk) begin
    if (rst || (rdy && r_rollback)) begin
      for (int i = 0; i < ROB_SIZE; i++) r_rob[i] <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_commit_sgn  <= 1'b0;
      r_st_commit   <= 1'b0;
      r_rollback    <= 1'b0;
      r_rob_entry   <= ENTRY_NULL;
      r_rob_des     <= REG_NULL;
      r_rob_result  <= '0;
      r_rollback_pc <= '0;
    end else if (rdy) begin
      r_commit_sgn <= w_commit;
      r_st_commit  <= w_commit && w_head.is_st;
      r_rollback   <= w_commit && w_mispred;

      if (w_alu_hit) begin
        r_rob[w_alu_idx].ready  <= 1'b1;
        r_rob[w_alu_idx].value  <= alu_value;
        r_rob[w_alu_idx].taken  <= alu_taken;
        r_rob[w_alu_idx].target <= alu_target;
      end
      if (w_lsb_hit) begin
        r_rob[w_lsb_idx].ready <= 1'b1;
        r_rob[w_lsb_idx].value <= lsb_value;
      end

      if (w_commit) begin
        r_rob[r_head].busy  <= 1'b0;
        r_rob[r_head].ready <= 1'b0;
        r_head              <= r_head + 1'b1;
        r_rob_entry         <= {1'b0, r_head};
        r_rob_des           <= w_head.rd;
        r_rob_result        <= w_head.value;
        if (w_mispred)
          r_rollback_pc <= w_head.taken ? w_head.target : (w_head.pc + 32'd4);
      end

      // Tail never aliases a retiring head: that needs count 0 or 16.
      if (w_issue) begin
        r_rob[r_tail] <= '{busy: 1'b1, ready: 1'b0, is_br: issue_is_br, is_st: issue_is_st,
                           pred: issue_pred, taken: 1'b0, rd: issue_rd, pc: issue_pc,
                           value: 32'd0, target: 32'd0};
        r_tail <= r_tail + 1'b1;
      end

      if (w_issue && !w_commit)
        r_count <= r_count + 1'b1;
      else if (!w_issue && w_commit)
        r_count <= r_count - 1'b1;
    end
  end

  assign rob_new_entry = {1'b0, r_tail};
  assign rob_full      = w_full;
  assign commit_sgn    = r_commit_sgn;
  assign rob_entry     = r_rob_entry;
  assign rob_des       = r_rob_des;
  assign rob_result    = r_rob_result;
  assign st_commit     = r_st_commit;
  assign rollback      = r_rollback;
  assign rollback_pc   = r_rollback_pc;

`ifdef ROB_BYPASS_EN
  logic [ROB_SIZE-1:0]       w_busy_vec;
  logic [ROB_SIZE-1:0]       w_ready_vec;
  logic [ROB_SIZE-1:0][31:0] w_value_vec;

  for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_pack
    assign w_busy_vec[gi]  = r_rob[gi].busy;
    assign w_ready_vec[gi] = r_rob[gi].ready;
    assign w_value_vec[gi] = r_rob[gi].value;
  end

  rob_bypass_mux u_byp_j (
    .i_tag       (qry_j),
    .i_busy      (w_busy_vec),
    .i_ready     (w_ready_vec),
    .i_value     (w_value_vec),
    .i_alu_valid (alu_valid),
    .i_alu_entry (alu_entry),
    .i_alu_value (alu_value),
    .i_lsb_valid (lsb_valid),
    .i_lsb_entry (lsb_entry),
    .i_lsb_value (lsb_value),
    .o_rdy       (qry_j_rdy),
    .o_val       (qry_j_val)
  );

  rob_bypass_mux u_byp_k (
    .i_tag       (qry_k),
    .i_busy      (w_busy_vec),
    .i_ready     (w_ready_vec),
    .i_value     (w_value_vec),
    .i_alu_valid (alu_valid),
    .i_alu_entry (alu_entry),
    .i_alu_value (alu_value),
    .i_lsb_valid (lsb_valid),
    .i_lsb_entry (lsb_entry),
    .i_lsb_value (lsb_value),
    .o_rdy       (qry_k_rdy),
    .o_val       (qry_k_val)
  );
`else
  logic w_unused_qry;
  assign w_unused_qry = ^{qry_j, qry_k};
  assign qry_j_rdy    = 1'b0;
  assign qry_j_val    = '0;
  assign qry_k_rdy    = 1'b0;
  assign qry_k_val    = '0;
`endif

endmodule
`default_nettype wire
